buzzer_alert_sequencer: RTL and testbench

Shares one buzzer tone generator between NUM_REQ alert sources such as alarm, error and key-click. It latches request pulses as pending, grants one source at a time by fixed priority (index 0 highest), and plays a beep/gap pattern for that source. Requester 0 can preempt other sources. The block sits between system event logic and the buzzer generator's play input.

---
 rtl/buzzer_alert_sequencer_if.sv | 34 +++
 rtl/buzzer_alert_sequencer.sv | 160 ++++++++++++++++
 tb/tb_buzzer_alert_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/buzzer_alert_sequencer_if.sv
`default_nettype none
//============================================================================
// buzzer_alert_sequencer_if : request/mute inputs and buzzer status outputs
// Rev 1.0
//============================================================================
interface buzzer_alert_sequencer_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic               mute;
    logic               tone_en;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic               done;

    modport master (
        output req,
        output mute,
        input  tone_en,
        input  grant,
        input  busy,
        input  done
    );

    modport slave (
        input  req,
        input  mute,
        output tone_en,
        output grant,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/buzzer_alert_sequencer.sv
`default_nettype none
//============================================================================
// buzzer_alert_sequencer : fixed-priority arbiter + beep/gap/holdoff player
// Rev 1.0
//============================================================================
module buzzer_alert_sequencer #(
    parameter int NUM_REQ    = 4,
    parameter int BEEP_MS    = 80,
    parameter int GAP_MS     = 40,
    parameter int HOLDOFF_MS = 200,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    buzzer_alert_sequencer_if.slave  bus
);

    localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_bl_w  = $clog2(NUM_REQ + 1);
    localparam logic [CNT_W-1:0]   c_beep_ticks    = CNT_W'(BEEP_MS);
    localparam logic [CNT_W-1:0]   c_gap_ticks     = CNT_W'(GAP_MS);
    localparam logic [CNT_W-1:0]   c_holdoff_ticks = CNT_W'(HOLDOFF_MS);
    localparam logic [NUM_REQ-1:0] c_one           = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BEEP    = 2'd1,
        S_GAP     = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t               r_state, w_state_nx;
    logic [NUM_REQ-1:0]   r_pending, w_pending_nx;
    logic [CNT_W-1:0]     r_tick_cnt, w_tick_cnt_nx, w_cnt_inc;
    logic [c_bl_w-1:0]    r_beeps_left, w_beeps_left_nx;
    logic [c_idx_w-1:0]   r_idx, w_idx_nx, w_low_idx;
    logic [NUM_REQ-1:0]   w_clr, w_set;
    logic                 w_done_nx, w_preempt;
    logic                 r_tone_en, r_busy, r_done;
    logic [NUM_REQ-1:0]   r_grant;

    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_idx = c_idx_w'(i);
            end
        end
    end

    assign w_cnt_inc = r_tick_cnt + 1'b1;
    assign w_preempt = ((r_state == S_BEEP) || (r_state == S_GAP)) &&
                       r_pending[0] && (r_idx != '0);

    always_comb begin
        w_state_nx      = r_state;
        w_tick_cnt_nx   = r_tick_cnt;
        w_beeps_left_nx = r_beeps_left;
        w_idx_nx        = r_idx;
        w_done_nx       = 1'b0;
        w_clr           = '0;
        w_set           = '0;
        if (w_preempt) begin
            // Aborted source goes back to pending so it replays in full later
            w_state_nx      = S_BEEP;
            w_idx_nx        = '0;
            w_beeps_left_nx = c_bl_w'(NUM_REQ);
            w_tick_cnt_nx   = '0;
            w_clr[0]        = 1'b1;
            w_set[r_idx]    = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending != '0) begin
                        w_state_nx       = S_BEEP;
                        w_idx_nx         = w_low_idx;
                        w_beeps_left_nx  = c_bl_w'(NUM_REQ - int'(w_low_idx));
                        w_tick_cnt_nx    = '0;
                        w_clr[w_low_idx] = 1'b1;
                    end
                end
                S_BEEP: begin
                    if (tick) begin
                        if (w_cnt_inc == c_beep_ticks) begin
                            w_tick_cnt_nx   = '0;
                            w_beeps_left_nx = r_beeps_left - 1'b1;
                            if (r_beeps_left != c_bl_w'(1)) begin
                                w_state_nx = S_GAP;
                            end else begin
                                w_done_nx  = 1'b1;
                                w_state_nx = (HOLDOFF_MS == 0) ? S_IDLE : S_HOLDOFF;
                            end
                        end else begin
                            w_tick_cnt_nx = w_cnt_inc;
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (w_cnt_inc == c_gap_ticks) begin
                            w_tick_cnt_nx = '0;
                            w_state_nx    = S_BEEP;
                        end else begin
                            w_tick_cnt_nx = w_cnt_inc;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (tick) begin
                        if (w_cnt_inc == c_holdoff_ticks) begin
                            w_tick_cnt_nx = '0;
                            w_state_nx    = S_IDLE;
                        end else begin
                            w_tick_cnt_nx = w_cnt_inc;
                        end
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    // A new request on the same edge as a clear of that bit wins
    assign w_pending_nx = (r_pending & ~w_clr) | w_set | bus.req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_tick_cnt   <= '0;
            r_beeps_left <= '0;
            r_idx        <= '0;
            r_tone_en    <= 1'b0;
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_pending    <= w_pending_nx;
            r_tick_cnt   <= w_tick_cnt_nx;
            r_beeps_left <= w_beeps_left_nx;
            r_idx        <= w_idx_nx;
            r_tone_en    <= (w_state_nx == S_BEEP) && !bus.mute;
            r_grant      <= ((w_state_nx == S_BEEP) || (w_state_nx == S_GAP)) ?
                            (c_one << w_idx_nx) : '0;
            r_busy       <= (w_state_nx != S_IDLE);
            r_done       <= w_done_nx;
        end
    end

    assign bus.tone_en = r_tone_en;
    assign bus.grant   = r_grant;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_alert_sequencer.sv
`default_nettype none
//============================================================================
// tb_buzzer_alert_sequencer : segment-table checks of beep/gap/holdoff timing
// Rev 1.0
//============================================================================
module tb_buzzer_alert_sequencer;

    localparam int N = 4;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         tick = 1'b0;
    logic         mute = 1'b0;
    logic [N-1:0] req  = '0;
    logic         use_h0 = 1'b0;

    always #5 clk = ~clk;

    buzzer_alert_sequencer_if #(.NUM_REQ(N)) bus ();
    buzzer_alert_sequencer_if #(.NUM_REQ(N)) bus_h0 ();

    assign bus.req     = req;
    assign bus.mute    = mute;
    assign bus_h0.req  = req;
    assign bus_h0.mute = mute;

    buzzer_alert_sequencer #(
        .NUM_REQ(N), .BEEP_MS(80), .GAP_MS(40), .HOLDOFF_MS(200), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .bus(bus)
    );

    buzzer_alert_sequencer #(
        .NUM_REQ(N), .BEEP_MS(80), .GAP_MS(40), .HOLDOFF_MS(0), .CNT_W(16)
    ) dut_h0 (
        .clk(clk), .rst(rst), .tick(tick), .bus(bus_h0)
    );

    logic         obs_tone, obs_busy, obs_done;
    logic [N-1:0] obs_grant;
    assign obs_tone  = use_h0 ? bus_h0.tone_en : bus.tone_en;
    assign obs_grant = use_h0 ? bus_h0.grant   : bus.grant;
    assign obs_busy  = use_h0 ? bus_h0.busy    : bus.busy;
    assign obs_done  = use_h0 ? bus_h0.done    : bus.done;

    // One segment: outputs must hold these values for every cycle of 'ticks'
    // tick periods (ticks==0: a single cycle, during which req is pulsed).
    typedef struct {
        logic [N-1:0] req;
        logic         mute;
        int           ticks;
        logic         tone;
        logic [N-1:0] grant;
        logic         busy;
        logic         done_first;
    } seg_t;

    seg_t  tbl[$];
    string tbl_tag[$];

    int          checks   = 0;
    int          failures = 0;
    bit          seg_bad;
    logic [6:0]  seg_got, seg_exp;
    int          seg_at;

    function automatic seg_t mk(input logic [N-1:0] r, input logic m, input int t,
                                input logic tn, input logic [N-1:0] g,
                                input logic b, input logic d);
        seg_t s;
        s.req = r; s.mute = m; s.ticks = t;
        s.tone = tn; s.grant = g; s.busy = b; s.done_first = d;
        return s;
    endfunction

    task automatic add(input seg_t s, input string tag);
        tbl.push_back(s);
        tbl_tag.push_back(tag);
    endtask

    task automatic add_play(input logic [N-1:0] g, input int nb, input logic m, input int sc);
        for (int b = 0; b < nb; b++) begin
            add(mk('0, m, 80, !m, g, 1'b1, 1'b0), $sformatf("sc%0d.beep%0d", sc, b));
            if (b < nb - 1)
                add(mk('0, m, 40, 1'b0, g, 1'b1, 1'b0), $sformatf("sc%0d.gap%0d", sc, b));
        end
    endtask

    task automatic cyc(input logic tk);
        tick = tk;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic sample(input seg_t s, input bit first, input int at);
        logic exp_done;
        exp_done = first ? s.done_first : 1'b0;
        if (!seg_bad && ({obs_tone, obs_grant, obs_busy, obs_done} !==
                         {s.tone, s.grant, s.busy, exp_done})) begin
            seg_bad = 1'b1;
            seg_got = {obs_tone, obs_grant, obs_busy, obs_done};
            seg_exp = {s.tone, s.grant, s.busy, exp_done};
            seg_at  = at;
        end
    endtask

    task automatic run_seg(input seg_t s, input string tag);
        seg_bad = 1'b0;
        seg_at  = 0;
        mute    = s.mute;
        if (s.ticks == 0) begin
            sample(s, 1'b1, 0);
            req = s.req;
            cyc(1'b0);
            req = '0;
        end else begin
            for (int k = 0; k < s.ticks; k++) begin
                sample(s, (k == 0), 2 * k);
                cyc(1'b0);
                sample(s, 1'b0, 2 * k + 1);
                cyc(1'b1);
            end
        end
        checks++;
        if (seg_bad) begin
            failures++;
            $display("FAIL %s at cycle %0d: tone/grant/busy/done got %b_%b_%b_%b required %b_%b_%b_%b",
                     tag, seg_at, seg_got[6], seg_got[5:2], seg_got[1], seg_got[0],
                     seg_exp[6], seg_exp[5:2], seg_exp[1], seg_exp[0]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cyc(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Scenarios 1 (audible) and 4 (muted): source 2, two beeps
        for (int m = 0; m < 2; m++) begin
            add(mk('0, m[0], 0, 1'b0, '0, 1'b0, 1'b0), $sformatf("sc%0d.idle", m ? 4 : 1));
            add(mk(4'b0100, m[0], 0, 1'b0, '0, 1'b0, 1'b0), $sformatf("sc%0d.req", m ? 4 : 1));
            add(mk('0, m[0], 0, 1'b0, '0, 1'b0, 1'b0), $sformatf("sc%0d.pend", m ? 4 : 1));
            add_play(4'b0100, 2, m[0], m ? 4 : 1);
            add(mk('0, m[0], 200, 1'b0, '0, 1'b1, 1'b1), $sformatf("sc%0d.hold", m ? 4 : 1));
            add(mk('0, m[0], 3, 1'b0, '0, 1'b0, 1'b0), $sformatf("sc%0d.end", m ? 4 : 1));
        end
        // Scenario 2: simultaneous requests 0 and 1
        add(mk(4'b0011, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0), "sc2.req");
        add(mk('0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0), "sc2.pend");
        add_play(4'b0001, 4, 1'b0, 2);
        add(mk('0, 1'b0, 200, 1'b0, '0, 1'b1, 1'b1), "sc2.hold0");
        add(mk('0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0), "sc2.idle_mid");
        add_play(4'b0010, 3, 1'b0, 2);
        add(mk('0, 1'b0, 200, 1'b0, '0, 1'b1, 1'b1), "sc2.hold1");
        add(mk('0, 1'b0, 3, 1'b0, '0, 1'b0, 1'b0), "sc2.end");
        // Scenario 3: source 0 preempts source 3 at tick 30 of its beep
        add(mk(4'b1000, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0), "sc3.req3");
        add(mk('0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0), "sc3.pend3");
        add(mk('0, 1'b0, 30, 1'b1, 4'b1000, 1'b1, 1'b0), "sc3.beep3_part");
        add(mk(4'b0001, 1'b0, 0, 1'b1, 4'b1000, 1'b1, 1'b0), "sc3.req0");
        add(mk('0, 1'b0, 0, 1'b1, 4'b1000, 1'b1, 1'b0), "sc3.pend0");
        add_play(4'b0001, 4, 1'b0, 3);
        add(mk('0, 1'b0, 200, 1'b0, '0, 1'b1, 1'b1), "sc3.hold0");
        add(mk('0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0), "sc3.idle_mid");
        add_play(4'b1000, 1, 1'b0, 3);
        add(mk('0, 1'b0, 200, 1'b0, '0, 1'b1, 1'b1), "sc3.hold3");
        add(mk('0, 1'b0, 3, 1'b0, '0, 1'b0, 1'b0), "sc3.end");

        do_reset();
        foreach (tbl[i]) run_seg(tbl[i], tbl_tag[i]);

        // Scenario 5: reset during source 1's gap with source 2 pending
        do_reset();
        run_seg(mk(4'b0010, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0), "sc5.req1");
        run_seg(mk('0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0), "sc5.pend1");
        run_seg(mk('0, 1'b0, 80, 1'b1, 4'b0010, 1'b1, 1'b0), "sc5.beep");
        run_seg(mk('0, 1'b0, 10, 1'b0, 4'b0010, 1'b1, 1'b0), "sc5.gap");
        run_seg(mk(4'b0100, 1'b0, 0, 1'b0, 4'b0010, 1'b1, 1'b0), "sc5.req2");
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        run_seg(mk('0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0), "sc5.after_rst");
        run_seg(mk('0, 1'b0, 300, 1'b0, '0, 1'b0, 1'b0), "sc5.no_regrant");

        // Scenario 6: zero holdoff, source 0 re-requests during its last beep
        use_h0 = 1'b1;
        do_reset();
        run_seg(mk(4'b0001, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0), "sc6.req");
        run_seg(mk('0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0), "sc6.pend");
        for (int b = 0; b < 3; b++) begin
            run_seg(mk('0, 1'b0, 80, 1'b1, 4'b0001, 1'b1, 1'b0), $sformatf("sc6.beep%0d", b));
            run_seg(mk('0, 1'b0, 40, 1'b0, 4'b0001, 1'b1, 1'b0), $sformatf("sc6.gap%0d", b));
        end
        run_seg(mk('0, 1'b0, 50, 1'b1, 4'b0001, 1'b1, 1'b0), "sc6.last_a");
        run_seg(mk(4'b0001, 1'b0, 0, 1'b1, 4'b0001, 1'b1, 1'b0), "sc6.rereq");
        run_seg(mk('0, 1'b0, 30, 1'b1, 4'b0001, 1'b1, 1'b0), "sc6.last_b");
        run_seg(mk('0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b1), "sc6.done_idle");
        for (int b = 0; b < 4; b++) begin
            run_seg(mk('0, 1'b0, 80, 1'b1, 4'b0001, 1'b1, 1'b0), $sformatf("sc6.rbeep%0d", b));
            if (b < 3)
                run_seg(mk('0, 1'b0, 40, 1'b0, 4'b0001, 1'b1, 1'b0), $sformatf("sc6.rgap%0d", b));
        end
        run_seg(mk('0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b1), "sc6.done2");
        run_seg(mk('0, 1'b0, 5, 1'b0, '0, 1'b0, 1'b0), "sc6.end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
